// File: rtl/ecc_mem_scrub_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : ecc_mem_scrub_arbiter
// Description : Single-port sequencer arbitrating a user requester against a
//               background scrubber in front of an ECC-protected memory port.
// Revision    : 1.0 - initial release
// ============================================================================
module ecc_mem_scrub_arbiter #(
    parameter int DATA_WIDTH     = 8,
    parameter int ADDR_WIDTH     = 3,
    parameter int READ_LATENCY   = 4,
    parameter int WRITE_LATENCY  = 5,
    parameter int SCRUB_INTERVAL = 64
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_req_valid,
    input  logic                  i_req_we,
    input  logic [ADDR_WIDTH-1:0] i_req_addr,
    input  logic [DATA_WIDTH-1:0] i_req_wdata,
    output logic                  o_req_ready,
    output logic                  o_rsp_valid,
    output logic [DATA_WIDTH-1:0] o_rsp_rdata,
    output logic                  o_rsp_err,
    output logic                  o_mem_en,
    output logic                  o_mem_we,
    output logic [ADDR_WIDTH-1:0] o_mem_addr,
    output logic [DATA_WIDTH-1:0] o_mem_din,
    input  logic [DATA_WIDTH-1:0] i_mem_dout,
    input  logic                  i_mem_err,
    input  logic                  i_scrub_en,
    output logic                  o_scrub_busy,
    output logic [15:0]           o_scrub_fix_cnt
);

    localparam int LAT_MAX = (READ_LATENCY > WRITE_LATENCY) ? READ_LATENCY : WRITE_LATENCY;
    localparam int LAT_W   = $clog2(LAT_MAX + 1);
    localparam int TMR_W   = $clog2(SCRUB_INTERVAL);

    localparam logic [LAT_W-1:0] C_RD_LAST  = LAT_W'(READ_LATENCY - 1);
    localparam logic [LAT_W-1:0] C_WR_LAST  = LAT_W'(WRITE_LATENCY - 1);
    localparam logic [TMR_W-1:0] C_TMR_LAST = TMR_W'(SCRUB_INTERVAL - 1);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_USER_RD  = 3'd1,
        ST_SCRUB_RD = 3'd2,
        ST_SCRUB_WB = 3'd3,
        ST_WR_HOLD  = 3'd4
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic [LAT_W-1:0]      r_lat_cnt;
    logic [TMR_W-1:0]      r_timer;
    logic                  r_pending;
    logic [ADDR_WIDTH-1:0] r_scrub_addr;
    logic [ADDR_WIDTH-1:0] r_wb_addr;
    logic [DATA_WIDTH-1:0] r_wb_data;
    logic                  r_hold_scrub;
    logic                  r_rsp_valid;
    logic [DATA_WIDTH-1:0] r_rsp_rdata;
    logic                  r_rsp_err;
    logic [15:0]           r_fix_cnt;
    logic                  w_scrub_issue;
    logic                  w_rd_done;

    assign w_rd_done = (r_lat_cnt == C_RD_LAST);

    always_comb begin
        w_state_next  = r_state;
        w_scrub_issue = 1'b0;
        o_mem_en      = 1'b0;
        o_mem_we      = 1'b0;
        o_mem_addr    = '0;
        o_mem_din     = '0;
        case (r_state)
            ST_IDLE: begin
                if (r_pending) begin
                    o_mem_en      = 1'b1;
                    o_mem_addr    = r_scrub_addr;
                    w_scrub_issue = 1'b1;
                    w_state_next  = ST_SCRUB_RD;
                end else if (i_req_valid) begin
                    o_mem_en     = 1'b1;
                    o_mem_we     = i_req_we;
                    o_mem_addr   = i_req_addr;
                    o_mem_din    = i_req_we ? i_req_wdata : '0;
                    w_state_next = i_req_we ? ST_WR_HOLD : ST_USER_RD;
                end
            end
            ST_USER_RD: begin
                if (w_rd_done) w_state_next = ST_IDLE;
            end
            ST_SCRUB_RD: begin
                if (w_rd_done) w_state_next = i_mem_err ? ST_SCRUB_WB : ST_IDLE;
            end
            ST_SCRUB_WB: begin
                o_mem_en     = 1'b1;
                o_mem_we     = 1'b1;
                o_mem_addr   = r_wb_addr;
                o_mem_din    = r_wb_data;
                w_state_next = ST_WR_HOLD;
            end
            ST_WR_HOLD: begin
                if (r_lat_cnt == C_WR_LAST) w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
        // Reset cycle forces every combinational output quiet.
        if (i_rst) begin
            w_state_next  = ST_IDLE;
            w_scrub_issue = 1'b0;
            o_mem_en      = 1'b0;
            o_mem_we      = 1'b0;
            o_mem_addr    = '0;
            o_mem_din     = '0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= ST_IDLE;
            r_lat_cnt    <= '0;
            r_timer      <= '0;
            r_pending    <= 1'b0;
            r_scrub_addr <= '0;
            r_wb_addr    <= '0;
            r_wb_data    <= '0;
            r_hold_scrub <= 1'b0;
            r_rsp_valid  <= 1'b0;
            r_rsp_rdata  <= '0;
            r_rsp_err    <= 1'b0;
            r_fix_cnt    <= '0;
        end else begin
            r_state     <= w_state_next;
            r_lat_cnt   <= (w_state_next != r_state) ? '0 : r_lat_cnt + LAT_W'(1);
            r_rsp_valid <= 1'b0;

            if (r_state == ST_USER_RD && w_rd_done) begin
                r_rsp_valid <= 1'b1;
                r_rsp_rdata <= i_mem_dout;
                r_rsp_err   <= i_mem_err;
            end

            if (r_state == ST_SCRUB_RD && w_rd_done) begin
                r_scrub_addr <= r_scrub_addr + ADDR_WIDTH'(1);
                r_wb_addr    <= r_scrub_addr;
                r_wb_data    <= i_mem_dout;
            end

            // Remember whether the coming write hold belongs to a scrub writeback.
            if (r_state == ST_SCRUB_WB) begin
                r_hold_scrub <= 1'b1;
                if (r_fix_cnt != 16'hFFFF) r_fix_cnt <= r_fix_cnt + 16'd1;
            end else if (r_state == ST_IDLE) begin
                r_hold_scrub <= 1'b0;
            end

            if (!i_scrub_en) begin
                r_timer   <= '0;
                r_pending <= 1'b0;
            end else if (r_timer == C_TMR_LAST) begin
                r_timer   <= '0;
                r_pending <= 1'b1;
            end else begin
                r_timer <= r_timer + TMR_W'(1);
                if (w_scrub_issue) r_pending <= 1'b0;
            end
        end
    end

    assign o_req_ready     = (r_state == ST_IDLE) && !r_pending && !i_rst;
    assign o_rsp_valid     = r_rsp_valid && !i_rst;
    assign o_rsp_rdata     = i_rst ? '0 : r_rsp_rdata;
    assign o_rsp_err       = r_rsp_err && !i_rst;
    assign o_scrub_busy    = !i_rst && ((r_state == ST_SCRUB_RD) || (r_state == ST_SCRUB_WB) ||
                                        ((r_state == ST_WR_HOLD) && r_hold_scrub));
    assign o_scrub_fix_cnt = r_fix_cnt;

endmodule
`default_nettype wire

// File: tb/tb_ecc_mem_scrub_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_ecc_mem_scrub_arbiter
// Description : Directed self-checking bench with a latency-accurate memory model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ecc_mem_scrub_arbiter;

    logic       i_clk = 1'b0;
    logic       i_rst;
    logic       i_req_valid;
    logic       i_req_we;
    logic [2:0] i_req_addr;
    logic [7:0] i_req_wdata;
    logic       o_req_ready;
    logic       o_rsp_valid;
    logic [7:0] o_rsp_rdata;
    logic       o_rsp_err;
    logic       o_mem_en;
    logic       o_mem_we;
    logic [2:0] o_mem_addr;
    logic [7:0] o_mem_din;
    logic [7:0] i_mem_dout;
    logic       i_mem_err;
    logic       i_scrub_en;
    logic       o_scrub_busy;
    logic [15:0] o_scrub_fix_cnt;

    int npass = 0;
    int nfail = 0;
    int ntot  = 0;
    int cyc   = 0;
    int t_prev;
    logic found;
    logic       err_arm;
    logic [2:0] err_addr;

    logic [7:0] mem [8];
    logic       pv [4];
    logic [2:0] pa [4];

    always #5 i_clk = ~i_clk;

    ecc_mem_scrub_arbiter dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_req_valid(i_req_valid), .i_req_we(i_req_we), .i_req_addr(i_req_addr),
        .i_req_wdata(i_req_wdata), .o_req_ready(o_req_ready),
        .o_rsp_valid(o_rsp_valid), .o_rsp_rdata(o_rsp_rdata), .o_rsp_err(o_rsp_err),
        .o_mem_en(o_mem_en), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
        .o_mem_din(o_mem_din), .i_mem_dout(i_mem_dout), .i_mem_err(i_mem_err),
        .i_scrub_en(i_scrub_en), .o_scrub_busy(o_scrub_busy),
        .o_scrub_fix_cnt(o_scrub_fix_cnt)
    );

    // Memory + decoder model: read data appears READ_LATENCY (4) cycles after issue.
    always @(posedge i_clk) begin
        cyc <= cyc + 1;
        if (i_rst) begin
            for (int i = 0; i < 8; i++) mem[i] <= 8'h10 + 8'(i);
            for (int i = 0; i < 4; i++) begin pv[i] <= 1'b0; pa[i] <= '0; end
        end else begin
            if (o_mem_en && o_mem_we) mem[o_mem_addr] <= o_mem_din;
            pv[0] <= o_mem_en && !o_mem_we;
            pa[0] <= o_mem_addr;
            for (int i = 1; i < 4; i++) begin pv[i] <= pv[i-1]; pa[i] <= pa[i-1]; end
        end
    end

    assign i_mem_dout = pv[3] ? mem[pa[3]] : 8'h00;
    assign i_mem_err  = pv[3] && err_arm && (pa[3] == err_addr);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntot++;
        assert (obs === exp) npass++;
        else begin
            nfail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic do_read(input logic [2:0] a, input logic [7:0] ed, input logic ee);
        @(negedge i_clk);
        i_req_valid = 1'b1; i_req_we = 1'b0; i_req_addr = a;
        #1;
        chk("rd_issue_ready", 32'(o_req_ready), 32'd1);
        chk("rd_issue_en", 32'({o_mem_en, o_mem_we}), 32'b10);
        chk("rd_issue_addr", 32'(o_mem_addr), 32'(a));
        for (int k = 1; k <= 6; k++) begin
            @(negedge i_clk);
            i_req_valid = 1'b0;
            #1;
            if (k == 5) begin
                chk("rd_rsp_valid", 32'(o_rsp_valid), 32'd1);
                chk("rd_rsp_rdata", 32'(o_rsp_rdata), 32'(ed));
                chk("rd_rsp_err", 32'(o_rsp_err), 32'(ee));
                chk("rd_ready_back", 32'(o_req_ready), 32'd1);
            end else begin
                chk("rd_no_rsp", 32'(o_rsp_valid), 32'd0);
            end
        end
    endtask

    task automatic wait_en(output logic f);
        f = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(negedge i_clk);
            #1;
            if (o_mem_en) begin
                f = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        i_rst = 1'b1; i_req_valid = 1'b0; i_req_we = 1'b0; i_req_addr = '0;
        i_req_wdata = '0; i_scrub_en = 1'b0; err_arm = 1'b0; err_addr = '0;

        // Reset state
        repeat (2) @(negedge i_clk);
        #1;
        chk("rst_ready", 32'(o_req_ready), 32'd0);
        chk("rst_outs", 32'({o_mem_en, o_rsp_valid, o_scrub_busy}), 32'd0);
        chk("rst_fix_cnt", 32'(o_scrub_fix_cnt), 32'd0);
        i_rst = 1'b0;
        @(negedge i_clk);
        #1;
        chk("idle_ready", 32'(o_req_ready), 32'd1);

        // User write 0xA5 @3
        @(negedge i_clk);
        i_req_valid = 1'b1; i_req_we = 1'b1; i_req_addr = 3'd3; i_req_wdata = 8'hA5;
        #1;
        chk("wr_issue", 32'({o_req_ready, o_mem_en, o_mem_we}), 32'b111);
        chk("wr_addr_din", 32'({o_mem_addr, o_mem_din}), 32'({3'd3, 8'hA5}));
        for (int k = 1; k <= 6; k++) begin
            @(negedge i_clk);
            i_req_valid = 1'b0; i_req_we = 1'b0;
            #1;
            if (k <= 5) chk("wr_hold", 32'({o_req_ready, o_mem_en}), 32'd0);
            else        chk("wr_done_ready", 32'(o_req_ready), 32'd1);
        end

        do_read(3'd3, 8'hA5, 1'b0);

        // Read with a corrected error: flagged, no writeback
        err_arm = 1'b1; err_addr = 3'd6;
        do_read(3'd6, 8'h16, 1'b1);
        err_arm = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge i_clk);
            #1;
            chk("no_user_wb", 32'(o_mem_en), 32'd0);
        end
        chk("fix_cnt_user", 32'(o_scrub_fix_cnt), 32'd0);

        // Background scrub walk 0..7 -> 0 with an error on address 5
        err_arm = 1'b1; err_addr = 3'd5;
        @(negedge i_clk);
        i_scrub_en = 1'b1;
        t_prev = cyc;
        for (int i = 0; i < 9; i++) begin
            wait_en(found);
            chk("scrub_found", 32'(found), 32'd1);
            chk("scrub_rd", 32'({o_mem_we, o_mem_addr}), 32'(i % 8));
            chk("scrub_spacing", 32'(cyc - t_prev), 32'd64);
            t_prev = cyc;
            if (i == 4) chk("fix_cnt_before", 32'(o_scrub_fix_cnt), 32'd0);
            if (i == 5) begin
                for (int k = 1; k <= 11; k++) begin
                    @(negedge i_clk);
                    #1;
                    if (k == 5) begin
                        chk("scrub_wb", 32'({o_mem_en, o_mem_we, o_mem_addr}), 32'b11_101);
                        chk("scrub_wb_din", 32'(o_mem_din), 32'h15);
                    end else if (k < 11) begin
                        chk("scrub_busy", 32'({o_scrub_busy, o_req_ready, o_mem_en}), 32'b100);
                    end else begin
                        chk("scrub_done", 32'({o_scrub_busy, o_req_ready}), 32'b01);
                        chk("fix_cnt_after", 32'(o_scrub_fix_cnt), 32'd1);
                    end
                end
            end
        end
        err_arm = 1'b0;
        repeat (10) @(negedge i_clk);
        i_scrub_en = 1'b0;
        repeat (3) @(negedge i_clk);

        // Pending scrub collides with a user read: scrub goes first
        i_scrub_en = 1'b1;
        repeat (63) @(negedge i_clk);
        #1;
        chk("timer_not_yet", 32'(o_mem_en), 32'd0);
        @(negedge i_clk);
        i_req_valid = 1'b1; i_req_we = 1'b0; i_req_addr = 3'd2;
        #1;
        chk("collide_scrub_first", 32'({o_req_ready, o_mem_en, o_mem_we, o_mem_addr}), 32'b01_0_001);
        repeat (5) @(negedge i_clk);
        #1;
        chk("collide_user_after", 32'({o_req_ready, o_mem_en, o_mem_we, o_mem_addr}), 32'b11_0_010);
        for (int k = 1; k <= 5; k++) begin
            @(negedge i_clk);
            i_req_valid = 1'b0; i_scrub_en = 1'b0;
            #1;
        end
        chk("collide_rsp", 32'({o_rsp_valid, o_rsp_rdata}), 32'({1'b1, 8'h12}));

        // Reset in the middle of a read: response abandoned
        @(negedge i_clk);
        i_req_valid = 1'b1; i_req_we = 1'b0; i_req_addr = 3'd3;
        #1;
        chk("mid_rd_issue", 32'(o_mem_en), 32'd1);
        @(negedge i_clk);
        i_req_valid = 1'b0;
        @(negedge i_clk);
        i_rst = 1'b1;
        #1;
        chk("mid_rst_quiet", 32'({o_req_ready, o_rsp_valid, o_mem_en}), 32'd0);
        @(negedge i_clk);
        i_rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge i_clk);
            #1;
            chk("mid_rst_no_rsp", 32'(o_rsp_valid), 32'd0);
        end
        chk("mid_rst_fix_cnt", 32'(o_scrub_fix_cnt), 32'd0);
        do_read(3'd3, 8'h13, 1'b0);

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
`default_nettype wire
